iq_correlator: RTL and testbench

- Upstream measurement stage for `single_freq_synth_core`.
- Correlates the signed ADC sample stream against the core's reference quadrature outputs `I`/`Q` over a fixed window of 2^WIN_LOG2 samples.
- Produces signed amplitude estimates `I_o`/`Q_o`, which feed the synth core's `I_o`/`Q_o` inputs so it can rebuild (or cancel) the measured tone.
- Also used stand-alone as a single-bin lock-in detector.

---
 rtl/iq_correlator.sv | 164 ++++++++++++++++
 tb/tb_iq_correlator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iq_correlator.sv
// iq_correlator: single-bin lock-in detector.
// Multiplies the signed ADC stream by the in-phase and quadrature references.
// Integrates the products over 2^WIN_LOG2 accepted samples.
// Scales, saturates and latches the two sums as signed amplitude estimates.
module iq_correlator #(
   parameter int DW       = 10,
   parameter int WIN_LOG2 = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_en,
   input  logic signed [DW-1:0] adc_data,
   input  logic signed [DW-1:0] ref_i,
   input  logic signed [DW-1:0] ref_q,
   input  logic                 start,
   input  logic                 cont,
   output logic                 busy,
   output logic                 done,
   output logic signed [DW-1:0] I_o,
   output logic signed [DW-1:0] Q_o
);

   // Product width, accumulator width (full growth over one window) and counter width.
   localparam int PW    = 2 * DW;
   localparam int AW    = 2 * DW + WIN_LOG2;
   localparam int CW    = WIN_LOG2 + 1;
   // A full-scale reference (about 2^(DW-1)) and the 2^WIN_LOG2 window together give
   // a gain of about 2^(WIN_LOG2+DW-1). The window average of A*cos^2 is A/2.
   // Shifting by one bit less than the gain therefore returns the amplitude A.
   localparam int SHIFT = WIN_LOG2 + DW - 2;

   localparam logic [CW-1:0]        LAST_CNT = CW'((2 ** WIN_LOG2) - 1);
   localparam logic signed [AW-1:0] SAT_MAX  = AW'((2 ** (DW - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(2 ** (DW - 1)));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]        cnt_q;
   logic                 p_vld_q;
   logic signed [PW-1:0] pi_q, pq_q;
   logic signed [AW-1:0] acc_i_q, acc_q_q;
   logic signed [DW-1:0] i_est_q, q_est_q;
   logic                 done_q;

   logic                 accept;
   logic                 last_sample;
   logic                 clear_win;
   logic signed [PW-1:0] adc_ext, ref_i_ext, ref_q_ext;
   logic signed [AW-1:0] sh_i, sh_q;
   logic signed [DW-1:0] sat_i, sat_q;

   // Sample acceptance, window end and window restart conditions.
   always_comb begin
      accept      = (state_q == S_ACCUM) && sample_en;
      last_sample = accept && (cnt_q == LAST_CNT);
      clear_win   = ((state_q == S_IDLE) && start) || ((state_q == S_LATCH) && cont);
   end

   // Window sequencing: IDLE -> ACCUM -> DRAIN -> LATCH -> IDLE, or -> ACCUM if cont.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_ACCUM;
         S_ACCUM: if (last_sample) state_d = S_DRAIN;
         S_DRAIN: state_d = S_LATCH;
         S_LATCH: state_d = cont ? S_ACCUM : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sign-extend the operands so that each product is formed at full 2*DW width.
   always_comb begin
      adc_ext   = {{DW{adc_data[DW-1]}}, adc_data};
      ref_i_ext = {{DW{ref_i[DW-1]}}, ref_i};
      ref_q_ext = {{DW{ref_q[DW-1]}}, ref_q};
   end

   // Two-stage multiply-accumulate pipeline with the accepted-sample counter.
   // Stage 1 registers the products and stage 2 folds them into the accumulators.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         p_vld_q <= 1'b0;
         pi_q    <= '0;
         pq_q    <= '0;
         acc_i_q <= '0;
         acc_q_q <= '0;
      end else if (clear_win) begin
         cnt_q   <= '0;
         p_vld_q <= 1'b0;
         acc_i_q <= '0;
         acc_q_q <= '0;
      end else begin
         p_vld_q <= accept;
         if (accept) begin
            pi_q  <= adc_ext * ref_i_ext;
            pq_q  <= adc_ext * ref_q_ext;
            cnt_q <= cnt_q + 1'b1;
         end
         if (p_vld_q) begin
            acc_i_q <= acc_i_q + {{WIN_LOG2{pi_q[PW-1]}}, pi_q};
            acc_q_q <= acc_q_q + {{WIN_LOG2{pq_q[PW-1]}}, pq_q};
         end
      end
   end

   // Floor-scale both sums and clamp them to the signed DW-bit output range.
   always_comb begin
      sh_i = acc_i_q >>> SHIFT;
      sh_q = acc_q_q >>> SHIFT;
      if (sh_i > SAT_MAX) begin
         sat_i = SAT_MAX[DW-1:0];
      end else if (sh_i < SAT_MIN) begin
         sat_i = SAT_MIN[DW-1:0];
      end else begin
         sat_i = sh_i[DW-1:0];
      end
      if (sh_q > SAT_MAX) begin
         sat_q = SAT_MAX[DW-1:0];
      end else if (sh_q < SAT_MIN) begin
         sat_q = SAT_MIN[DW-1:0];
      end else begin
         sat_q = sh_q[DW-1:0];
      end
   end

   // Result registers: written once per window in LATCH, and held until the next LATCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_est_q <= '0;
         q_est_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state_q == S_LATCH);
         if (state_q == S_LATCH) begin
            i_est_q <= sat_i;
            q_est_q <= sat_q;
         end
      end
   end

   // busy covers LATCH as well, so that it falls on the same edge that raises done.
   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign I_o  = i_est_q;
   assign Q_o  = q_est_q;

endmodule

// File: tb/tb_iq_correlator.sv
// Directed, table-driven bench for iq_correlator with a 16-sample window.
module tb_iq_correlator;

   localparam int DW = 10;
   localparam int WL = 4;
   localparam int N  = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 sample_en;
   logic signed [DW-1:0] adc_data;
   logic signed [DW-1:0] ref_i;
   logic signed [DW-1:0] ref_q;
   logic                 start;
   logic                 cont;
   logic                 busy;
   logic                 done;
   logic signed [DW-1:0] I_o;
   logic signed [DW-1:0] Q_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [39:0] adc_pat;   // 4-sample repeating patterns, element j at [j*10 +: 10]
      logic [39:0] ri_pat;
      logic [39:0] rq_pat;
      int          gap;       // idle cycles before each strobe
      int          exp_i;
      int          exp_q;
      int          tol;
   } vec_t;

   vec_t vecs[8];

   iq_correlator #(.DW(DW), .WIN_LOG2(WL)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .adc_data  (adc_data),
      .ref_i     (ref_i),
      .ref_q     (ref_q),
      .start     (start),
      .cont      (cont),
      .busy      (busy),
      .done      (done),
      .I_o       (I_o),
      .Q_o       (Q_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   function automatic logic [39:0] pat4(input int a, input int b, input int c, input int d);
      return {d[9:0], c[9:0], b[9:0], a[9:0]};
   endfunction

   task automatic apply(input int v, input int n);
      int j;
      j        = (n % 4) * 10;
      adc_data = $signed(vecs[v].adc_pat[j +: 10]);
      ref_i    = $signed(vecs[v].ri_pat[j +: 10]);
      ref_q    = $signed(vecs[v].rq_pat[j +: 10]);
   endtask

   // Count the ticks until done is seen, giving up after 40.
   task automatic wait_done(output int ticks);
      ticks = 0;
      while (!done && ticks < 40) begin
         tick();
         ticks++;
      end
   endtask

   // One full window from vector v; optionally pulse start again mid-window.
   task automatic run_window(input int v, input bit mid_start);
      int t;
      apply(v, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d busy after start", v), int'(busy), 1, 0);
      for (int n = 0; n < N; n++) begin
         for (int g = 0; g < vecs[v].gap; g++) begin
            sample_en = 1'b0;
            tick();
         end
         apply(v, n);
         sample_en = 1'b1;
         if (mid_start && n == 5) start = 1'b1;
         tick();
         sample_en = 1'b0;
         start     = 1'b0;
      end
      wait_done(t);
      chk($sformatf("v%0d done latency", v), t + 1, 3, 0);
      chk($sformatf("v%0d I_o", v), int'(I_o), vecs[v].exp_i, vecs[v].tol);
      chk($sformatf("v%0d Q_o", v), int'(Q_o), vecs[v].exp_q, vecs[v].tol);
      chk($sformatf("v%0d busy with done", v), int'(busy), 0, 0);
      tick();
      chk($sformatf("v%0d done one cycle", v), int'(done), 0, 0);
   endtask

   initial begin
      int t;
      int dcount;

      // DC in-phase, gapped DC, both saturation limits, tone at 0 and 90 degrees,
      // the negative quadrature path (floor rounding), and a negative DC input.
      vecs[0] = '{pat4(200, 200, 200, 200), pat4(511, 511, 511, 511), pat4(0, 0, 0, 0), 0, 399, 0, 0};
      vecs[1] = '{pat4(200, 200, 200, 200), pat4(511, 511, 511, 511), pat4(0, 0, 0, 0), 2, 399, 0, 0};
      vecs[2] = '{pat4(511, 511, 511, 511), pat4(511, 511, 511, 511), pat4(0, 0, 0, 0), 0, 511, 0, 0};
      vecs[3] = '{pat4(-512, -512, -512, -512), pat4(511, 511, 511, 511), pat4(0, 0, 0, 0), 0, -512, 0, 0};
      vecs[4] = '{pat4(300, 0, -300, 0), pat4(511, 0, -511, 0), pat4(0, 511, 0, -511), 0, 300, 0, 4};
      vecs[5] = '{pat4(0, 300, 0, -300), pat4(511, 0, -511, 0), pat4(0, 511, 0, -511), 0, 0, 300, 4};
      vecs[6] = '{pat4(200, 200, 200, 200), pat4(0, 0, 0, 0), pat4(-511, -511, -511, -511), 0, 0, -400, 0};
      vecs[7] = '{pat4(-100, -100, -100, -100), pat4(511, 511, 511, 511), pat4(0, 0, 0, 0), 0, -200, 0, 0};

      rst = 1'b1; sample_en = 1'b0; start = 1'b0; cont = 1'b0;
      adc_data = '0; ref_i = '0; ref_q = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset I_o", int'(I_o), 0, 0);
      chk("reset Q_o", int'(Q_o), 0, 0);
      chk("reset busy", int'(busy), 0, 0);
      chk("reset done", int'(done), 0, 0);

      for (int v = 0; v < 8; v++) begin
         run_window(v, 1'b0);
      end

      // A start pulse in the middle of a window must not restart or lengthen it.
      run_window(0, 1'b1);

      // A reset part-way through a window discards it and clears the outputs.
      apply(7, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 8; n++) begin
         sample_en = 1'b1;
         tick();
      end
      sample_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst mid busy", int'(busy), 0, 0);
      chk("rst mid done", int'(done), 0, 0);
      chk("rst mid I_o", int'(I_o), 0, 0);
      chk("rst mid Q_o", int'(Q_o), 0, 0);
      dcount = 0;
      for (int n = 0; n < 24; n++) begin
         sample_en = 1'b1;
         tick();
         if (done) dcount++;
      end
      sample_en = 1'b0;
      chk("rst no done", dcount, 0, 0);
      run_window(0, 1'b0);

      // Back-to-back windows with cont held, strobing on every cycle.
      apply(0, 0);
      cont      = 1'b1;
      sample_en = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_done(t);
      chk("cont w1 I_o", int'(I_o), 399, 0);
      chk("cont w1 busy", int'(busy), 1, 0);
      adc_data = -10'sd100;
      tick();
      wait_done(t);
      chk("cont done spacing", t + 1, N + 2, 0);
      chk("cont w2 I_o", int'(I_o), -200, 0);
      cont = 1'b0;
      tick();
      wait_done(t);
      chk("cont w3 spacing", t + 1, N + 2, 0);
      chk("cont w3 I_o", int'(I_o), -200, 0);
      chk("cont w3 busy", int'(busy), 0, 0);
      sample_en = 1'b0;
      tick();
      chk("cont w3 done one cycle", int'(done), 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
